// File: rtl/lab_result_bcd_if.sv
// Upstream strobe plus downstream valid/ready bundle for lab_result_bcd.
// out_raw exists only when OUT_RAW_EN is defined.
interface lab_result_bcd_if;
  logic       in_valid;
  logic [6:0] in_result;
  logic       out_ready;
  logic       out_valid;
  logic       out_sign;
  logic [3:0] out_tens;
  logic [3:0] out_ones;
  logic       fifo_full;
  logic       overflow;
`ifdef OUT_RAW_EN
  logic [6:0] out_raw;
`endif

  modport master (
`ifdef OUT_RAW_EN
    input  out_raw,
`endif
    output in_valid, in_result, out_ready,
    input  out_valid, out_sign, out_tens, out_ones, fifo_full, overflow
  );

  modport slave (
`ifdef OUT_RAW_EN
    output out_raw,
`endif
    input  in_valid, in_result, out_ready,
    output out_valid, out_sign, out_tens, out_ones, fifo_full, overflow
  );
endinterface

// File: rtl/lab_result_bcd.sv
// Buffers 7-bit signed results in a FIFO and converts each to sign + 2 BCD digits
// with a 7-step double-dabble engine. Optional OUT_RAW_EN adds out_raw.
module lab_result_bcd #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  lab_result_bcd_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              pop, push, full;
  logic              ovf_q, sign_q, out_valid_q;
  logic [7:0]        bcd;
  logic [DATA_W-1:0] mag;
  logic [2:0]        step;
  logic [DATA_W-1:0] head, head_mag;
  logic [3:0]        ones_adj, tens_adj;
`ifdef OUT_RAW_EN
  logic [DATA_W-1:0] raw_q;
`endif

  assign full  = (count == CW'(DEPTH));
  assign pop   = (state == IDLE) && (count != '0);
  // A full FIFO still accepts when the FSM frees a slot on the same edge.
  assign push  = bus.in_valid && (!full || pop);
  assign head  = mem[rd_ptr];
  assign head_mag = head[DATA_W-1] ? (~head + DATA_W'(1)) : head;

  assign ones_adj = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
  assign tens_adj = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.in_valid && !push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sign_q      <= 1'b0;
      bcd         <= '0;
      mag         <= '0;
      step        <= '0;
      out_valid_q <= 1'b0;
`ifdef OUT_RAW_EN
      raw_q       <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (pop) begin
          sign_q <= head[DATA_W-1];
          mag    <= head_mag;
          bcd    <= '0;
          step   <= '0;
          state  <= CONV;
`ifdef OUT_RAW_EN
          raw_q  <= head;
`endif
        end
        CONV: begin
          // Adjust nibbles, then shift {bcd, mag} left by one.
          {bcd, mag} <= {tens_adj, ones_adj, mag} << 1;
          step <= step + 3'd1;
          if (step == 3'd6) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sign  = sign_q;
  assign bus.out_tens  = bcd[7:4];
  assign bus.out_ones  = bcd[3:0];
  assign bus.fifo_full = full;
  assign bus.overflow  = ovf_q;
`ifdef OUT_RAW_EN
  assign bus.out_raw   = raw_q;
`endif
endmodule
